// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared road, phase and lamp encodings for the traffic
//             intersection sequencer and any consumer of TG green times.
//  Contents : ROAD_N..ROAD_W road codes, phase_e enum, LAMP_* lamp vectors,
//             default green clamp limits, lamp_for() helper.
//  Revision : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Road encoding, shared with the adaptation unit on next_road / cur_road.
  localparam logic [1:0] ROAD_N = 2'd0;
  localparam logic [1:0] ROAD_E = 2'd1;
  localparam logic [1:0] ROAD_S = 2'd2;
  localparam logic [1:0] ROAD_W = 2'd3;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2
  } phase_e;

  // Lamp vectors are {R,Y,G}, exactly one bit set.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Default green-time clamp limits, in ticks.
  localparam int DEF_TG_MIN = 10;
  localparam int DEF_TG_MAX = 120;

  // Lamp shown by the road that owns (or last owned) green.
  function automatic logic [2:0] lamp_for(input phase_e ph);
    logic [2:0] lamp;
    case (ph)
      PH_GREEN:  lamp = LAMP_G;
      PH_YELLOW: lamp = LAMP_Y;
      default:   lamp = LAMP_R;
    endcase
    return lamp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tg_clamp.sv
`default_nettype none
// ============================================================================
//  Module   : tg_clamp
//  Purpose  : Combinational saturating clamp for an 8-bit green time.
//             bit7 set means the producer underflowed and is treated as the
//             floor; otherwise the value is limited to [TG_MIN, TG_MAX].
//  Ports    : tg_i [7:0] raw green time in ticks
//             tg_o [7:0] clamped green time in ticks
//  Revision : 1.0 - initial release
// ============================================================================
module tg_clamp
  import traffic_pkg::*;
#(
  parameter int TG_MIN = DEF_TG_MIN,
  parameter int TG_MAX = DEF_TG_MAX
) (
  input  logic [7:0] tg_i,
  output logic [7:0] tg_o
);

  localparam logic [7:0] c_tg_min = 8'(TG_MIN);
  localparam logic [7:0] c_tg_max = 8'(TG_MAX);

  always_comb begin
    tg_o = tg_i;
    if (tg_i[7]) begin
      tg_o = c_tg_min;
    end else if (tg_i < c_tg_min) begin
      tg_o = c_tg_min;
    end else if (tg_i > c_tg_max) begin
      tg_o = c_tg_max;
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_sequencer
//  Purpose  : Cycles the approaches N->E->S->W through GREEN, YELLOW and
//             ALL_RED, consuming per-road green times TGn..TGw. next_road is
//             published at the GREEN->YELLOW edge so the adaptation unit has
//             YELLOW_T+ALLRED_T ticks to settle the matching TG before it is
//             sampled on the ALL_RED->GREEN edge.
//  Ports    : clk, reset (sync, active-low), tick (time-base enable)
//             TGn/TGe/TGs/TGw [7:0] green times, bit7 = underflow
//             next_road, cur_road [1:0]; phase [1:0]; time_left [7:0]
//             light_n/e/s/w [2:0] {R,Y,G}; cycle_done (W green->yellow)
//  Option   : TRAFFIC_PREEMPT_EN adds preempt / preempt_road inputs that
//             force the running green to yellow and steer the next green.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TG_MIN   = DEF_TG_MIN,
  parameter int TG_MAX   = DEF_TG_MAX,
  parameter int YELLOW_T = 4,
  parameter int ALLRED_T = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic       preempt,
  input  logic [1:0] preempt_road,
`endif
  input  logic [7:0] TGn,
  input  logic [7:0] TGe,
  input  logic [7:0] TGs,
  input  logic [7:0] TGw,
  output logic [1:0] next_road,
  output logic [1:0] cur_road,
  output logic [1:0] phase,
  output logic [7:0] time_left,
  output logic [2:0] light_n,
  output logic [2:0] light_e,
  output logic [2:0] light_s,
  output logic [2:0] light_w,
  output logic       cycle_done
);

  localparam logic [7:0] c_yellow = 8'(YELLOW_T);
  localparam logic [7:0] c_allred = 8'(ALLRED_T);
`ifdef TRAFFIC_PREEMPT_EN
  localparam logic [7:0] c_tg_max = 8'(TG_MAX);
`endif

  phase_e     phase_q, phase_d;
  logic [1:0] cur_q, cur_d;
  logic [1:0] next_q, next_d;
  logic [7:0] left_q, left_d;
  logic       done_q, done_d;
  logic [2:0] lights_q [4];
  logic [2:0] lights_d [4];

  logic [1:0] w_target;
  logic [7:0] w_tg_sel;
  logic [7:0] w_tg_clamped;

  // Road that the next ALL_RED->GREEN edge will grant. A preempt request
  // outside GREEN only steers this target.
`ifdef TRAFFIC_PREEMPT_EN
  assign w_target = (preempt && (phase_q != PH_GREEN)) ? preempt_road : next_q;
`else
  assign w_target = next_q;
`endif

  always_comb begin
    case (w_target)
      ROAD_N:  w_tg_sel = TGn;
      ROAD_E:  w_tg_sel = TGe;
      ROAD_S:  w_tg_sel = TGs;
      default: w_tg_sel = TGw;
    endcase
  end

  tg_clamp #(
    .TG_MIN (TG_MIN),
    .TG_MAX (TG_MAX)
  ) u_tg_clamp (
    .tg_i (w_tg_sel),
    .tg_o (w_tg_clamped)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q <= PH_ALL_RED;
      cur_q   <= ROAD_W;
      next_q  <= ROAD_N;
      left_q  <= c_allred;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lights_q[i] <= LAMP_R;
      end
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      left_q  <= left_d;
      done_q  <= done_d;
      for (int i = 0; i < 4; i++) begin
        lights_q[i] <= lights_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Everything holds on non-tick cycles; a phase ends on
  // the tick where time_left is 1, so it lasts exactly its loaded value.
  // --------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    next_d  = next_q;
    left_d  = left_q;
    done_d  = 1'b0;
    if (tick) begin
      next_d = w_target;
`ifdef TRAFFIC_PREEMPT_EN
      if (preempt && (phase_q == PH_GREEN) && (cur_q != preempt_road)) begin
        phase_d = PH_YELLOW;
        left_d  = c_yellow;
        next_d  = preempt_road;
        done_d  = (cur_q == ROAD_W);
      end else if (preempt && (phase_q == PH_GREEN)) begin
        // Preempting road keeps green for as long as the request is held.
        left_d = c_tg_max;
      end else
`endif
      if (left_q > 8'd1) begin
        left_d = left_q - 8'd1;
      end else begin
        case (phase_q)
          PH_ALL_RED: begin
            phase_d = PH_GREEN;
            cur_d   = w_target;
            left_d  = w_tg_clamped;
          end
          PH_GREEN: begin
            phase_d = PH_YELLOW;
            left_d  = c_yellow;
            next_d  = cur_q + 2'd1;
            done_d  = (cur_q == ROAD_W);
          end
          default: begin
            phase_d = PH_ALL_RED;
            left_d  = c_allred;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic: lamps are computed from the next state and registered on
  // the same edge as phase, so only the owning road can ever be non-red.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_lamp
    assign lights_d[g] = (cur_d == 2'(g)) ? lamp_for(phase_d) : LAMP_R;
  end

  assign next_road  = next_q;
  assign cur_road   = cur_q;
  assign phase      = phase_q;
  assign time_left  = left_q;
  assign cycle_done = done_q;
  assign light_n    = lights_q[0];
  assign light_e    = lights_q[1];
  assign light_s    = lights_q[2];
  assign light_w    = lights_q[3];

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_sequencer
//  Purpose  : Self-checking bench: a tick-level reference model of the
//             intersection is compared with the DUT every cycle, plus directed
//             literal checks of reset, cycle length, clamping, next_road
//             timing and mid-phase reset, then a randomized soak.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_sequencer;

  localparam int TG_MIN = 10;
  localparam int TG_MAX = 120;
  localparam int YEL    = 4;
  localparam int AR     = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [7:0] TGn, TGe, TGs, TGw;
  logic [1:0] next_road, cur_road, phase;
  logic [7:0] time_left;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic       cycle_done;
`ifdef TRAFFIC_PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_road = 2'd0;
`endif

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .TG_MIN   (TG_MIN),
    .TG_MAX   (TG_MAX),
    .YELLOW_T (YEL),
    .ALLRED_T (AR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt      (preempt),
    .preempt_road (preempt_road),
`endif
    .TGn          (TGn),
    .TGe          (TGe),
    .TGs          (TGs),
    .TGw          (TGw),
    .next_road    (next_road),
    .cur_road     (cur_road),
    .phase        (phase),
    .time_left    (time_left),
    .light_n      (light_n),
    .light_e      (light_e),
    .light_s      (light_s),
    .light_w      (light_w),
    .cycle_done   (cycle_done)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: phase 0=all red, 1=green, 2=yellow; each phase lasts its
  // loaded number of ticks, green length is the clamped TG of the road.
  // --------------------------------------------------------------------------
  int m_ph = 0, m_cur = 3, m_next = 0, m_left = AR;
  bit m_cd = 1'b0;

  function automatic int clampv(input int v);
    if (v >= 128)   return TG_MIN;
    if (v < TG_MIN) return TG_MIN;
    if (v > TG_MAX) return TG_MAX;
    return v;
  endfunction

  function automatic int exp_lamp(input int road);
    if (road != m_cur) return 4;
    if (m_ph == 1)     return 1;
    if (m_ph == 2)     return 2;
    return 4;
  endfunction

  always @(posedge clk) begin
    int tg [4];
    tg[0] = TGn; tg[1] = TGe; tg[2] = TGs; tg[3] = TGw;
    m_cd = 1'b0;
    if (!reset) begin
      m_ph = 0; m_cur = 3; m_next = 0; m_left = AR;
    end else if (tick) begin
      if (m_left > 1) begin
        m_left = m_left - 1;
      end else if (m_ph == 0) begin
        m_ph = 1; m_cur = m_next; m_left = clampv(tg[m_next]);
      end else if (m_ph == 1) begin
        m_ph = 2; m_left = YEL; m_cd = (m_cur == 3); m_next = (m_cur + 1) % 4;
      end else begin
        m_ph = 0; m_left = AR;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("phase", phase, m_ph);
      chk("cur_road", cur_road, m_cur);
      chk("next_road", next_road, m_next);
      chk("time_left", time_left, m_left);
      chk("cycle_done", cycle_done, m_cd);
      chk("light_n", light_n, exp_lamp(0));
      chk("light_e", light_e, exp_lamp(1));
      chk("light_s", light_s, exp_lamp(2));
      chk("light_w", light_w, exp_lamp(3));
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  int g_len [4];
  int total_len;

  // Counts cycles (tick every cycle) up to and including the next cycle_done.
  task automatic measure_cycle();
    int n = 0;
    for (int r = 0; r < 4; r++) g_len[r] = 0;
    total_len = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (phase == 2'd1) g_len[cur_road]++;
      if (cycle_done) break;
    end
    total_len = n;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL measure_cycle: no cycle_done within %0d cycles", n);
    end
  endtask

  task automatic wait_state(input string name, input int ph, input int cur, input int left);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(phase == ph && cur_road == cur && (left < 0 || time_left == left)) && n < 2000);
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL %s: state not reached, got phase %0d road %0d left %0d", name, phase, cur_road, time_left);
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0;
    TGn = 8'd30; TGe = 8'd30; TGs = 8'd30; TGw = 8'd30;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset state
    chk("rst_phase", phase, 0);
    chk("rst_cur", cur_road, 3);
    chk("rst_next", next_road, 0);
    chk("rst_left", time_left, AR);
    chk("rst_light_n", light_n, 3'b100);
    chk("rst_cd", cycle_done, 0);

    // Release: two all-red ticks then N green for 30
    reset = 1'b1; tick = 1'b1;
    @(negedge clk);
    chk("ar_left1", time_left, 1);
    chk("ar_phase1", phase, 0);
    @(negedge clk);
    chk("n_green_phase", phase, 1);
    chk("n_green_cur", cur_road, 0);
    chk("n_green_left", time_left, 30);
    chk("n_green_light_n", light_n, 3'b001);
    chk("n_green_light_e", light_e, 3'b100);
    chk("n_green_light_w", light_w, 3'b100);

    // Full cycle 20/25/30/35
    TGn = 8'd20; TGe = 8'd25; TGs = 8'd30; TGw = 8'd35;
    measure_cycle();   // align to a cycle_done
    measure_cycle();
    chk("cyc_total", total_len, 134);
    chk("cyc_g_n", g_len[0], 20);
    chk("cyc_g_e", g_len[1], 25);
    chk("cyc_g_s", g_len[2], 30);
    chk("cyc_g_w", g_len[3], 35);

    // Clamping
    TGe = 8'd5; TGs = 8'd200; TGw = 8'd127;
    measure_cycle();
    chk("clamp_total", total_len, 20 + 10 + 10 + 120 + 24);
    chk("clamp_g_e", g_len[1], 10);
    chk("clamp_g_s", g_len[2], 10);
    chk("clamp_g_w", g_len[3], 120);

    // next_road timing and late TGe change
    TGe = 8'd25; TGs = 8'd30;
    wait_state("n_yellow", 2, 0, YEL);
    chk("nr_after_n_green", next_road, 1);
    wait_state("n_allred_last", 0, 0, 1);
    chk("nr_before_e_green", next_road, 1);
    TGe = 8'd77;
    @(negedge clk);
    chk("late_tge_phase", phase, 1);
    chk("late_tge_cur", cur_road, 1);
    chk("late_tge_left", time_left, 77);

    // Reset in the middle of S green
    wait_state("s_green_17", 1, 2, 17);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_phase", phase, 0);
    chk("midrst_next", next_road, 0);
    chk("midrst_cur", cur_road, 3);
    chk("midrst_light_s", light_s, 3'b100);
    reset = 1'b1;

    // Randomized soak against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tick  = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: TGn = 8'($urandom_range(0, 255));
          1: TGe = 8'($urandom_range(0, 255));
          2: TGs = 8'($urandom_range(0, 255));
          default: TGw = 8'($urandom_range(0, 255));
        endcase
      end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Clocked consumer of the per-road green times produced by the adaptation logic; drives the other end of the `next_road` / `TG*` interface.
- Cycles the four approaches N→E→S→W→N through GREEN, YELLOW and ALL_RED phases, and drives per-road lamp outputs.
- Publishes `next_road` early, during the YELLOW phase, so the adaptation logic can settle the matching `TG` before it is sampled.

Parameters:
- `TG_MIN`, 10: minimum green duration in ticks; clamp floor.
- `TG_MAX`, 120: maximum green duration in ticks; clamp ceiling.
- `YELLOW_T`, 4: yellow duration in ticks (≥1).
- `ALLRED_T`, 2: all-red clearance duration in ticks (≥1).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-cycle time-base enable (nominally 1 Hz); all timing advances only on cycles with `tick`=1.
- `TGn`, `TGe`, `TGs`, `TGw`  in  8 each  green times from the adaptation unit, in ticks; bit7=1 means arithmetic underflow.
- `next_road`  out  2  road to be granted green next (0=N, 1=E, 2=S, 3=W).
- `cur_road`  out  2  road currently owning or last owning green.
- `phase`  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW.
- `time_left`  out  8  ticks remaining in the current phase, including the current tick.
- `light_n`, `light_e`, `light_s`, `light_w`  out  3 each  lamp vector {R,Y,G}, one-hot.
- `cycle_done`  out  1  one-clk pulse when the W green→yellow transition occurs.

Behaviour:
- Reset (`reset`=0 at a clk edge):
  - `phase`=ALL_RED, `cur_road`=3, `next_road`=0, `time_left`=`ALLRED_T`.
  - All lights=3'b100; `cycle_done`=0.
  - Reset overrides `tick` in the same cycle and aborts any phase mid-count.
- Timer: on each `tick`, if `time_left`>1 then decrement; if `time_left`==1 then perform the phase transition and load the new duration. A phase therefore lasts exactly its loaded value in ticks. Non-tick cycles hold all state.
- ALL_RED→GREEN:
  - `cur_road` ← `next_road`.
  - `time_left` ← clamp(TG[`next_road`]), sampled on this clk edge.
  - `next_road` unchanged.
- GREEN→YELLOW:
  - `time_left` ← `YELLOW_T`.
  - `next_road` ← `cur_road`+1 (mod 4, wraps 3→0).
  - `cycle_done`=1 for this single clk if `cur_road`==3.
- YELLOW→ALL_RED: `time_left` ← `ALLRED_T`.
- Clamp rule:
  - bit7 set (negative underflow) → `TG_MIN`.
  - Value < `TG_MIN` → `TG_MIN`.
  - Value > `TG_MAX` → `TG_MAX`.
  - Otherwise the value unchanged.
- Lights, registered, updated on the same edge as `phase`:
  - `cur_road` = G (3'b001) in GREEN, Y (3'b010) in YELLOW, R in ALL_RED.
  - All other roads always R (3'b100).
  - Never two non-red roads at once.
- `TG` inputs are ignored except on the ALL_RED→GREEN edge; input changes mid-green do not alter the running count.
- `next_road` is stable for ≥`YELLOW_T`+`ALLRED_T` ticks before it is sampled. This is the settling budget granted to the adaptation unit.

Optional Feature:
- Macro `TRAFFIC_PREEMPT_EN`.
- With it defined, two extra ports are added: `preempt` (in, 1) and `preempt_road` (in, 2).
  - `preempt`=1 during GREEN of a road other than `preempt_road` forces YELLOW, load `YELLOW_T`, on the next `tick`.
  - `next_road` ← `preempt_road`.
  - While `preempt` stays high, the preempted road's GREEN holds `time_left` at `TG_MAX` and does not decrement.
  - Release resumes normal sequencing from that road.
  - `preempt` during YELLOW or ALL_RED only retargets `next_road`.
- Without the macro: the ports are absent and the sequence is strictly round-robin.

Decomposition:
- Shared package `traffic_pkg`:
  - Road encoding constants `ROAD_N`..`ROAD_W`.
  - Phase enum (ALL_RED/GREEN/YELLOW).
  - Lamp encodings `LAMP_R`/`LAMP_Y`/`LAMP_G`.
  - Default `TG_MIN`/`TG_MAX`.
- Sub-module `tg_clamp`: combinational 8-bit saturating clamp with bit7 underflow detect; reused by any future consumer of `TG` values.

Test Plan:
- Reset release with `TGn`=30 and `tick` every cycle:
  - ALL_RED for 2 ticks.
  - N green with `time_left`=30 on the first GREEN cycle.
  - `light_n`=001; others 100.
- Full cycle with `TGn`/`TGe`/`TGs`/`TGw`=20/25/30/35:
  - Green lengths are 20/25/30/35 ticks; YELLOW 4; ALL_RED 2.
  - Total 110+24=134 ticks per cycle.
  - `cycle_done` pulses once per cycle.
- Clamping:
  - `TGe`=5 → 10 ticks.
  - `TGs`=200 (bit7 set) → 10 ticks.
  - `TGw`=127 → 120 ticks.
- `next_road` timing:
  - `next_road` changes 0→1 on the N GREEN→YELLOW edge and stays 1 until E's green starts.
  - `TGe` changed 1 tick before ALL_RED ends is the value loaded.
- Reset mid-phase: assert `reset`=0 during S green with `time_left`=17 → next edge all red, `phase`=ALL_RED, `next_road`=0.
- With `TRAFFIC_PREEMPT_EN`:
  - `preempt_road`=2 asserted during N green → N yellow next tick, then ALL_RED, then S green.
  - S green is held while `preempt`=1.
  - After release the sequence resumes S→W.
